// File: rtl/imem_prog_if.sv
// Fetch and program-load bus for imem_prog.
//   fetch  : fetch_en, fetch_addr -> q, q_valid (one-cycle registered read)
//   load   : load_start, load_base, load_len, load_valid, load_data
//            -> load_ready, busy, load_done
// master drives requests and write data; slave is the memory.
interface imem_prog_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 6
) ();
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [N-1:0]      q;
  logic              q_valid;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [N-1:0]      load_data;
  logic              load_ready;
  logic              busy;
  logic              load_done;

  modport master (
    output fetch_en, fetch_addr, load_start, load_base, load_len, load_valid, load_data,
    input  q, q_valid, load_ready, busy, load_done
  );

  modport slave (
    input  fetch_en, fetch_addr, load_start, load_base, load_len, load_valid, load_data,
    output q, q_valid, load_ready, busy, load_done
  );
endinterface

// File: rtl/imem_prog.sv
// Run-time programmable instruction memory for the LEGv8 single-cycle core.
// Registered fetch port (1-cycle latency) plus a valid/ready load port that
// writes load_len words starting at load_base, wrapping modulo DEPTH.
// Ports: clk, reset (sync, active-high), bus (imem_prog_if.slave).
// Reset restores the built-in default program image.
module imem_prog #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic       clk,
  input  logic       reset,
  imem_prog_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic [N-1:0]      q;
  logic              q_valid;
  logic              load_ready;
  logic              busy;
  logic              load_done;
  logic              wr_en;
  logic [N-1:0]      rd_words [DEPTH];

  // Default program image, zero-extended or truncated to N bits.
  function automatic logic [N-1:0] img_word(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'hf8000000;
      1:       w = 32'hf8008001;
      2:       w = 32'hf8010002;
      3:       w = 32'hf8018003;
      4:       w = 32'hf8020004;
      5:       w = 32'hf8028005;
      6:       w = 32'hf8030006;
      7:       w = 32'hf8400007;
      8:       w = 32'hf8408008;
      9:       w = 32'hf8410009;
      10:      w = 32'hf841800a;
      11:      w = 32'hf842000b;
      12:      w = 32'hf842800c;
      13:      w = 32'hf843000d;
      14:      w = 32'hcb0e01ce;
      15:      w = 32'hb400004e;
      16:      w = 32'hcb01000f;
      17:      w = 32'h8b01000f;
      18:      w = 32'hf803800f;
      default: w = 32'h0;
    endcase
    return N'(w);
  endfunction

  // load_ready is only high in LOAD, so this is the per-word write strobe.
  assign wr_en = bus.load_valid & load_ready;

  // One register per word so each gets its own reset value and write decode.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [N-1:0] word;
    always_ff @(posedge clk) begin
      if (reset) begin
        word <= img_word(i);
      end else if (wr_en && (ptr == ADDR_W'(i))) begin
        word <= bus.load_data;
      end
    end
    assign rd_words[i] = word;
  end

  // Fetch port and load FSM; all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      q          <= '0;
      q_valid    <= 1'b0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      // Fetch uses the registered busy, so a fetch in the load_start cycle is served.
      if (bus.fetch_en && !busy) begin
        q       <= rd_words[bus.fetch_addr];
        q_valid <= 1'b1;
      end else begin
        q_valid <= 1'b0;
      end

      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_start) begin
            if (bus.load_len == '0) begin
              load_done <= 1'b1;
            end else begin
              ptr        <= bus.load_base;
              cnt        <= bus.load_len;
              state      <= LOAD;
              busy       <= 1'b1;
              load_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            ptr <= ptr + ADDR_W'(1);
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q          = q;
  assign bus.q_valid    = q_valid;
  assign bus.load_ready = load_ready;
  assign bus.busy       = busy;
  assign bus.load_done  = load_done;
endmodule

// File: tb/tb_imem_prog.sv
// Self-checking bench for imem_prog: directed scenarios followed by random
// traffic, every cycle compared against a word-count based reference model.
module tb_imem_prog;
  localparam int unsigned N      = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] IMG [19] = '{
    32'hf8000000, 32'hf8008001, 32'hf8010002, 32'hf8018003, 32'hf8020004,
    32'hf8028005, 32'hf8030006, 32'hf8400007, 32'hf8408008, 32'hf8410009,
    32'hf841800a, 32'hf842000b, 32'hf842800c, 32'hf843000d, 32'hcb0e01ce,
    32'hb400004e, 32'hcb01000f, 32'h8b01000f, 32'hf803800f};

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_seen = 0;

  imem_prog_if #(.N(N), .ADDR_W(ADDR_W)) bus ();
  imem_prog #(.N(N), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: memory contents, words still to be written, and flags.
  logic [31:0] m_mem [DEPTH];
  int          m_rem;
  int          m_ptr;
  logic        m_done;
  logic        m_dbusy;
  logic [31:0] m_q;
  logic        m_qv;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 19) m_mem[i] = IMG[i];
      else        m_mem[i] = 32'h0;
    end
    m_rem = 0; m_ptr = 0; m_done = 1'b0; m_dbusy = 1'b0; m_q = 32'h0; m_qv = 1'b0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic old_busy, nd, ndb;
    if (reset) begin
      model_reset();
      return;
    end
    old_busy = (m_rem > 0) || m_dbusy;
    if (bus.fetch_en && !old_busy) begin
      m_q  = m_mem[bus.fetch_addr];
      m_qv = 1'b1;
    end else begin
      m_qv = 1'b0;
    end
    nd = 1'b0; ndb = 1'b0;
    if (m_rem > 0) begin
      if (bus.load_valid) begin
        m_mem[m_ptr] = bus.load_data;
        m_ptr = (m_ptr + 1) % DEPTH;
        m_rem--;
        if (m_rem == 0) begin nd = 1'b1; ndb = 1'b1; end
      end
    end else if (!m_dbusy && bus.load_start) begin
      if (bus.load_len == 0) nd = 1'b1;
      else begin
        m_rem = int'(bus.load_len);
        m_ptr = int'(bus.load_base);
      end
    end
    m_done  = nd;
    m_dbusy = ndb;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: update model, take the edge, compare all outputs.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("q",          bus.q,          m_q);
    check("q_valid",    32'(bus.q_valid),    32'(m_qv));
    check("load_ready", 32'(bus.load_ready), 32'(m_rem > 0));
    check("busy",       32'(bus.busy),       32'(m_rem > 0 || m_dbusy));
    check("load_done",  32'(bus.load_done),  32'(m_done));
    if (bus.load_done) done_seen++;
  endtask

  task automatic idle_in();
    bus.fetch_en = 1'b0; bus.fetch_addr = '0; bus.load_start = 1'b0;
    bus.load_base = '0; bus.load_len = '0; bus.load_valid = 1'b0; bus.load_data = '0;
  endtask

  task automatic fetch(input int a);
    bus.fetch_en = 1'b1;
    bus.fetch_addr = ADDR_W'(a);
    cyc();
  endtask

  initial begin
    model_reset();
    idle_in();
    reset = 1'b1;
    cyc(); cyc();
    check("rst_q", bus.q, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;

    // Default image, back-to-back fetches.
    fetch(0);  check("img0",  bus.q, 32'hf8000000);
    fetch(14); check("img14", bus.q, 32'hcb0e01ce);
    fetch(18); check("img18", bus.q, 32'hf803800f);
    fetch(19); check("img19", bus.q, 32'h00000000);
    check("img19_v", 32'(bus.q_valid), 32'h1);
    bus.fetch_en = 1'b0;
    cyc();

    // Wrapping load at the top of memory.
    bus.load_start = 1'b1; bus.load_base = 6'd62; bus.load_len = 7'd3;
    cyc();
    bus.load_start = 1'b0; bus.load_valid = 1'b1;
    bus.load_data = 32'h11111111; cyc();
    bus.load_data = 32'h22222222; cyc();
    bus.load_data = 32'h33333333; cyc();
    check("wrap_done", 32'(bus.load_done), 32'h1);
    bus.load_valid = 1'b0;
    cyc();
    check("wrap_idle", 32'(bus.busy), 32'h0);
    fetch(62); check("w62", bus.q, 32'h11111111);
    fetch(63); check("w63", bus.q, 32'h22222222);
    fetch(0);  check("w0",  bus.q, 32'h33333333);
    fetch(1);  check("w1",  bus.q, 32'hf8008001);
    bus.fetch_en = 1'b0;
    cyc();

    // Stalled load with fetches and an ignored second load_start while busy.
    done_seen = 0;
    bus.load_start = 1'b1; bus.load_base = 6'd10; bus.load_len = 7'd4;
    cyc();
    for (int w = 0; w < 4; w++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = $urandom;
      bus.fetch_en   = 1'b1;
      bus.fetch_addr = ADDR_W'($urandom);
      bus.load_start = (w < 3);
      bus.load_base  = 6'd30;
      bus.load_len   = 7'd2;
      cyc();
      bus.load_valid = 1'b0;
      bus.load_start = 1'b0;
      if (w < 3) begin
        for (int g = 0; g < 4; g++) begin
          bus.fetch_addr = ADDR_W'($urandom);
          cyc();
          check("stall_busy", 32'(bus.busy), 32'h1);
        end
      end
    end
    bus.fetch_en = 1'b0;
    cyc(); cyc();
    check("stall_done_once", 32'(done_seen), 32'h1);
    fetch(30); check("ignored_start", bus.q, 32'h0);
    fetch(14); check("after_range", bus.q, 32'hcb0e01ce);
    bus.fetch_en = 1'b0;

    // Zero-length load.
    done_seen = 0;
    bus.load_start = 1'b1; bus.load_base = 6'd5; bus.load_len = 7'd0;
    cyc();
    bus.load_start = 1'b0;
    check("len0_done", 32'(bus.load_done), 32'h1);
    check("len0_busy", 32'(bus.busy), 32'h0);
    cyc();
    fetch(5); check("len0_mem", bus.q, 32'hf8028005);
    bus.fetch_en = 1'b0;

    // Reset part-way through a five-word load.
    bus.load_start = 1'b1; bus.load_base = 6'd0; bus.load_len = 7'd5;
    cyc();
    bus.load_start = 1'b0; bus.load_valid = 1'b1;
    bus.load_data = $urandom; cyc();
    bus.load_data = $urandom; cyc();
    bus.load_valid = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_busy",  32'(bus.busy),       32'h0);
    check("mid_rst_ready", 32'(bus.load_ready), 32'h0);
    fetch(0); check("mid_rst_w0", bus.q, 32'hf8000000);
    fetch(1); check("mid_rst_w1", bus.q, 32'hf8008001);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(99) == 0);
      bus.fetch_en   = $urandom_range(1) == 1;
      bus.fetch_addr = ADDR_W'($urandom);
      bus.load_start = ($urandom_range(15) == 0);
      bus.load_base  = ADDR_W'($urandom);
      bus.load_len   = ($urandom_range(3) == 0) ? 7'($urandom_range(64)) : 7'($urandom_range(6));
      bus.load_valid = ($urandom_range(2) != 0);
      bus.load_data  = $urandom;
      cyc();
    end

    // Drain any pending load, then sweep the whole memory.
    reset = 1'b0;
    idle_in();
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hdeadbeef;
    for (int c = 0; c < 70; c++) cyc();
    bus.load_valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) fetch(a);
    bus.fetch_en = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, synchronous-read instruction memory for the single-cycle LEGv8 datapath, successor to the fixed 64×32 combinational instruction ROM. It adds a registered fetch port and a valid/ready program-load port, so test programs can be written at run time without resynthesis. Synchronous reset restores the built-in default program image. It sits between the PC register and the decode stage; the load port is driven by the bench or a UART loader.

## Interface
- N, 32: instruction word width in bits.
- ADDR_W, 6: address width; depth DEPTH = 2**ADDR_W words.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- fetch_en  in  1  request a read of fetch_addr this cycle.
- fetch_addr  in  ADDR_W  word address to read.
- q  out  N  instruction word, registered.
- q_valid  out  1  q holds data for the request accepted in the previous cycle.
- load_start  in  1  one-cycle pulse that begins a program load.
- load_base  in  ADDR_W  first word address written; sampled on load_start.
- load_len  in  ADDR_W+1  number of words to write (0..DEPTH); sampled on load_start.
- load_valid  in  1  load_data is valid.
- load_data  in  N  word to write.
- load_ready  out  1  block accepts load_data this cycle.
- busy  out  1  a load is in progress, fetch is blocked.
- load_done  out  1  one-cycle pulse when a load completes.

## Operation
- Default image, restored on reset: words 0..18 = f8000000, f8008001, f8010002, f8018003, f8020004, f8028005, f8030006, f8400007, f8408008, f8410009, f841800a, f842000b, f842800c, f843000d, cb0e01ce, b400004e, cb01000f, 8b01000f, f803800f. Words 19..DEPTH-1 = 0. For N≠32, each image word is zero-extended or truncated to N bits.
- The FSM has three states: IDLE, LOAD and DONE.
  - IDLE: when load_start=1 and load_len≠0, the block latches ptr=load_base and cnt=load_len, then moves to LOAD.
  - IDLE, load_len=0: load_done pulses on the next cycle and the FSM stays in IDLE. The memory is unchanged.
  - LOAD: load_ready=1. On each load_valid&load_ready, mem[ptr]←load_data, ptr←ptr+1 modulo DEPTH (wraps from DEPTH-1 to 0), and cnt←cnt−1. When cnt reaches 1 and a word is accepted, the FSM moves to DONE.
  - DONE: load_done=1 and load_ready=0 for one cycle, then the FSM returns to IDLE.
- busy=1 in LOAD and DONE, 0 in IDLE. load_start is ignored while busy.
- Cycles in LOAD with load_valid=0 stall the load. No timeout.
- Fetch:
  - When fetch_en=1 and busy=0: q←mem[fetch_addr] and q_valid←1.
  - Otherwise q holds its value and q_valid←0.
  - fetch_en in the same cycle as load_start in IDLE: the fetch is served, then busy rises.
- reset in any state: FSM→IDLE, memory←default image, q=0, q_valid=0, load_ready=0, busy=0, load_done=0. A partially written program is discarded.

## Timing
- Fetch latency is 1 cycle: address at edge k, data on q and q_valid=1 after edge k+1.
- Back-to-back fetches give one word per cycle.
- load_start at edge k: busy=1 and load_ready=1 from edge k+1.
- The last word is accepted at edge m. DONE holds for cycle m+1 (load_done=1) and the FSM is in IDLE at edge m+2.
- A fetch issued in IDLE after DONE returns the newly written data. No read-before-write hazard is possible, because fetch is blocked while writing.
- A full load of L words with load_valid held at 1 takes L+2 cycles from load_start to busy=0.

## Test plan
- Reset, then fetch addresses 0, 14, 18, 19 on consecutive cycles -> q = f8000000, cb0e01ce, f803800f, 00000000, each one cycle after its address, with q_valid=1 on each.
- load_start with base=62, len=3, data 11111111/22222222/33333333 and load_valid held at 1 -> after load_done, fetching 62, 63, 0 returns 11111111, 22222222, 33333333, and word 1 is still f8008001.
- During a load, drop load_valid for 4 cycles between words -> cnt unchanged, load_done occurs exactly once after the last word, and busy=1 throughout.
- fetch_en=1 while busy -> q_valid=0 and q holds its previous value. A second load_start while busy is ignored: words written equal the first len only.
- load_start with len=0 -> load_done pulse on the next cycle, busy stays 0, and memory is unchanged.
- Assert reset after 2 of 5 load words -> busy=0 and load_ready=0 on the next cycle, and fetching 0 returns f8000000 (image restored).
